// File: rtl/mem_bist.sv
// mem_bist: March C- built-in self-test sequencer for an asynchronous AWxDW array.
//
// Drives the array's address/data/enable/rw inputs at one access per clock while a
// test runs. It checks every read against the expected background and stops at the
// first mismatch, reporting the failing address and the data word that was read.
// An external mux keyed on o_busy hands the array back to functional logic.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      one-cycle test request, honoured only in idle/done
//   o_busy       high while the march runs
//   o_done       high from test completion until the next accepted start
//   o_pass       valid with o_done; 1 = no mismatch seen
//   o_fail_addr  address of the first mismatch (0 on pass)
//   o_fail_data  data read at the first mismatch (0 on pass)
//   o_mem_a      array address
//   o_mem_di     array write data
//   o_mem_e      array enable
//   o_mem_rw     1 = read, 0 = write
//   i_mem_d      array read data
module mem_bist #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW-1:0] o_fail_addr,
  output logic [DW-1:0] o_fail_data,
  output logic [AW-1:0] o_mem_a,
  output logic [DW-1:0] o_mem_di,
  output logic          o_mem_e,
  output logic          o_mem_rw,
  input  logic [DW-1:0] i_mem_d
);

  typedef enum logic [2:0] {
    StIdle,
    StM0,
    StM1,
    StM2,
    StM3,
    StM4,
    StM5,
    StDone
  } state_e;

  localparam logic [AW-1:0] AddrMax  = '1;
  localparam logic [AW-1:0] AddrZero = '0;
  localparam logic [DW-1:0] DataOnes = '1;
  localparam logic [DW-1:0] DataZero = '0;

  // Sequencer state: element, operation within a two-op element, address.
  state_e        r_state;
  state_e        w_state_d;
  logic          r_wr_phase;    // two-op elements: 0 = read slot, 1 = write slot
  logic          w_wr_phase_d;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_d;

  // Next values of the registered outputs.
  logic          w_busy_d;
  logic          w_done_d;
  logic          w_pass_d;
  logic [AW-1:0] w_fail_addr_d;
  logic [DW-1:0] w_fail_data_d;
  logic [AW-1:0] w_mem_a_d;
  logic [DW-1:0] w_mem_di_d;
  logic          w_mem_e_d;
  logic          w_mem_rw_d;

  // Current-cycle decode.
  logic          w_two_op;
  logic          w_read_now;
  logic [DW-1:0] w_exp_data;
  logic          w_mismatch;
  logic          w_accept;
  logic          w_clean_end;

  always_comb begin
    w_two_op    = (r_state == StM1) || (r_state == StM2) ||
                  (r_state == StM3) || (r_state == StM4);
    w_read_now  = (w_two_op && !r_wr_phase) || (r_state == StM5);
    // r1 is expected only in M2 and M4; every other read expects zeros.
    w_exp_data  = ((r_state == StM2) || (r_state == StM4)) ? DataOnes : DataZero;
    // The read cycle ends at this edge, so i_mem_d is the data being checked.
    w_mismatch  = w_read_now && (i_mem_d != w_exp_data);
    w_accept    = i_start && ((r_state == StIdle) || (r_state == StDone));
    w_clean_end = (r_state == StM5) && !w_mismatch && (r_addr == AddrMax);
  end

  // State register process.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_wr_phase  <= 1'b0;
      r_addr      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_mem_a     <= '0;
      o_mem_di    <= '0;
      o_mem_e     <= 1'b0;
      o_mem_rw    <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_wr_phase  <= w_wr_phase_d;
      r_addr      <= w_addr_d;
      o_busy      <= w_busy_d;
      o_done      <= w_done_d;
      o_pass      <= w_pass_d;
      o_fail_addr <= w_fail_addr_d;
      o_fail_data <= w_fail_data_d;
      o_mem_a     <= w_mem_a_d;
      o_mem_di    <= w_mem_di_d;
      o_mem_e     <= w_mem_e_d;
      o_mem_rw    <= w_mem_rw_d;
    end
  end

  // Next-state process: walks element / operation / address.
  always_comb begin
    w_state_d    = r_state;
    w_wr_phase_d = r_wr_phase;
    w_addr_d     = r_addr;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d    = StM0;
          w_wr_phase_d = 1'b0;
          w_addr_d     = AddrZero;
        end
      end
      StM0: begin
        if (r_addr == AddrMax) begin
          w_state_d = StM1;
          w_addr_d  = AddrZero;
        end else begin
          w_addr_d = r_addr + AW'(1);
        end
      end
      StM1, StM2: begin
        if (!r_wr_phase) begin
          if (w_mismatch) begin
            w_state_d = StDone;
            w_addr_d  = AddrZero;
          end else begin
            w_wr_phase_d = 1'b1;
          end
        end else begin
          w_wr_phase_d = 1'b0;
          if (r_addr == AddrMax) begin
            // M1 hands over to ascending M2; M2 to descending M3 starting at the top.
            w_state_d = (r_state == StM1) ? StM2 : StM3;
            w_addr_d  = (r_state == StM1) ? AddrZero : AddrMax;
          end else begin
            w_addr_d = r_addr + AW'(1);
          end
        end
      end
      StM3, StM4: begin
        if (!r_wr_phase) begin
          if (w_mismatch) begin
            w_state_d = StDone;
            w_addr_d  = AddrZero;
          end else begin
            w_wr_phase_d = 1'b1;
          end
        end else begin
          w_wr_phase_d = 1'b0;
          if (r_addr == AddrZero) begin
            // M3 hands over to descending M4; M4 to ascending M5 from address 0.
            w_state_d = (r_state == StM3) ? StM4 : StM5;
            w_addr_d  = (r_state == StM3) ? AddrMax : AddrZero;
          end else begin
            w_addr_d = r_addr - AW'(1);
          end
        end
      end
      StM5: begin
        if (w_mismatch || (r_addr == AddrMax)) begin
          w_state_d = StDone;
          w_addr_d  = AddrZero;
        end else begin
          w_addr_d = r_addr + AW'(1);
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_wr_phase_d = 1'b0;
        w_addr_d     = AddrZero;
      end
    endcase
  end

  // Output process: the access presented next cycle follows the next state, so the
  // array pins stay registered while the first access appears at the start edge.
  always_comb begin
    w_busy_d      = (w_state_d != StIdle) && (w_state_d != StDone);
    w_mem_e_d     = w_busy_d;
    w_mem_a_d     = w_busy_d ? w_addr_d : AddrZero;
    w_mem_rw_d    = 1'b1;
    w_mem_di_d    = DataZero;
    if (w_state_d == StM0) begin
      w_mem_rw_d = 1'b0;
    end else if (((w_state_d == StM1) || (w_state_d == StM2) ||
                  (w_state_d == StM3) || (w_state_d == StM4)) && w_wr_phase_d) begin
      w_mem_rw_d = 1'b0;
      // w1 in M1 and M3; w0 in M2 and M4.
      if ((w_state_d == StM1) || (w_state_d == StM3)) begin
        w_mem_di_d = DataOnes;
      end
    end

    w_done_d      = o_done;
    w_pass_d      = o_pass;
    w_fail_addr_d = o_fail_addr;
    w_fail_data_d = o_fail_data;
    if (w_accept) begin
      w_done_d      = 1'b0;
      w_pass_d      = 1'b0;
      w_fail_addr_d = '0;
      w_fail_data_d = '0;
    end else if (w_mismatch) begin
      // Only the first mismatch is recorded: the run aborts here.
      w_done_d      = 1'b1;
      w_pass_d      = 1'b0;
      w_fail_addr_d = o_mem_a;
      w_fail_data_d = i_mem_d;
    end else if (w_clean_end) begin
      w_done_d      = 1'b1;
      w_pass_d      = 1'b1;
      w_fail_addr_d = '0;
      w_fail_data_d = '0;
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed bench for mem_bist against a 64x4 array model with
// selectable stuck-at faults. Checks reset/idle values, the clean March C-
// access order and length, two fault aborts, an ignored mid-run start and a
// mid-run reset followed by a fresh run.
module tb_mem_bist;

  logic       clk;
  logic       i_rst;
  logic       i_start;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [5:0] o_fail_addr;
  logic [3:0] o_fail_data;
  logic [5:0] o_mem_a;
  logic [3:0] o_mem_di;
  logic       o_mem_e;
  logic       o_mem_rw;
  logic [3:0] w_mem_d;

  mem_bist #(
    .AW(6),
    .DW(4)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pass     (o_pass),
    .o_fail_addr(o_fail_addr),
    .o_fail_data(o_fail_data),
    .o_mem_a    (o_mem_a),
    .o_mem_di   (o_mem_di),
    .o_mem_e    (o_mem_e),
    .o_mem_rw   (o_mem_rw),
    .i_mem_d    (w_mem_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: write at the end of a write cycle, combinational read with faults.
  logic [3:0] mem [64];
  int         fault_mode;  // 0 none, 1 SA1 @42 bit0, 2 SA0 @1 bit3

  always @(posedge clk) begin
    if (o_mem_e && !o_mem_rw) mem[o_mem_a] <= o_mem_di;
  end

  always_comb begin
    w_mem_d = mem[o_mem_a];
    if (fault_mode == 1 && o_mem_a == 6'd42) w_mem_d[0] = 1'b1;
    if (fault_mode == 2 && o_mem_a == 6'd1)  w_mem_d[3] = 1'b0;
  end

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, 32'(o_busy), 0);
    check_eq({tag, "_done"}, 32'(o_done), 0);
    check_eq({tag, "_pass"}, 32'(o_pass), 0);
    check_eq({tag, "_fa"}, 32'(o_fail_addr), 0);
    check_eq({tag, "_fd"}, 32'(o_fail_data), 0);
    check_eq({tag, "_a"}, 32'(o_mem_a), 0);
    check_eq({tag, "_di"}, 32'(o_mem_di), 0);
    check_eq({tag, "_e"}, 32'(o_mem_e), 0);
    check_eq({tag, "_rw"}, 32'(o_mem_rw), 1);
  endtask

  // Expected March C- access order.
  typedef struct {
    logic [5:0] a;
    logic       rw;
    logic [3:0] di;
  } acc_t;
  acc_t exp_q[$];
  bit   seq_en;
  int   seq_idx;

  always @(negedge clk) begin
    if (!seq_en) begin
      seq_idx <= 0;
    end else if (o_mem_e) begin
      if (seq_idx < exp_q.size()) begin
        check_eq("seq_a", 32'(o_mem_a), 32'(exp_q[seq_idx].a));
        check_eq("seq_rw", 32'(o_mem_rw), 32'(exp_q[seq_idx].rw));
        if (!exp_q[seq_idx].rw) check_eq("seq_di", 32'(o_mem_di), 32'(exp_q[seq_idx].di));
      end else begin
        check_eq("seq_len", seq_idx, exp_q.size());
      end
      seq_idx <= seq_idx + 1;
    end
  end

  // Start a run and wait for done. poke_cyc > 0 pulses start (or rst) so that it is
  // sampled at the edge ending that cycle. Cycle k ends at the k-th edge after start.
  task automatic run(input int poke_cyc, input bit poke_rst, output int end_cyc,
                     output int busy_cyc);
    end_cyc  = -1;
    busy_cyc = 0;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check_eq("start_busy", 32'(o_busy), 1);
    check_eq("start_done", 32'(o_done), 0);
    check_eq("start_fa", 32'(o_fail_addr), 0);
    check_eq("start_e", 32'(o_mem_e), 1);
    check_eq("start_rw", 32'(o_mem_rw), 0);
    check_eq("start_a", 32'(o_mem_a), 0);
    busy_cyc = 1;
    for (int k = 1; k <= 700; k++) begin
      if (k == poke_cyc) begin
        if (poke_rst) i_rst = 1'b1;
        else i_start = 1'b1;
      end
      @(posedge clk);
      #1;
      i_rst   = 1'b0;
      i_start = 1'b0;
      if (k == poke_cyc && poke_rst) begin
        check_reset("midrun_rst");
        return;
      end
      if (o_busy) busy_cyc++;
      if (o_done) begin
        end_cyc = k;
        break;
      end
    end
  endtask

  int end_c;
  int busy_c;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    fault_mode = 0;
    seq_en     = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_e", 32'(o_mem_e), 0);
    end
    check_reset("idle");

    // Expected order: M0 w0 asc, M1 r0w1 asc, M2 r1w0 asc, M3 r0w1 desc,
    // M4 r1w0 desc, M5 r0 asc.
    for (int a = 0; a < 64; a++) exp_q.push_back('{6'(a), 1'b0, 4'h0});
    for (int a = 0; a < 64; a++) begin
      exp_q.push_back('{6'(a), 1'b1, 4'h0});
      exp_q.push_back('{6'(a), 1'b0, 4'hF});
    end
    for (int a = 0; a < 64; a++) begin
      exp_q.push_back('{6'(a), 1'b1, 4'h0});
      exp_q.push_back('{6'(a), 1'b0, 4'h0});
    end
    for (int a = 63; a >= 0; a--) begin
      exp_q.push_back('{6'(a), 1'b1, 4'h0});
      exp_q.push_back('{6'(a), 1'b0, 4'hF});
    end
    for (int a = 63; a >= 0; a--) begin
      exp_q.push_back('{6'(a), 1'b1, 4'h0});
      exp_q.push_back('{6'(a), 1'b0, 4'h0});
    end
    for (int a = 0; a < 64; a++) exp_q.push_back('{6'(a), 1'b1, 4'h0});

    // Clean run.
    seq_en = 1'b1;
    run(0, 1'b0, end_c, busy_c);
    @(negedge clk);
    seq_en = 1'b0;
    check_eq("clean_end", end_c, 640);
    check_eq("clean_busy_cycles", busy_c, 640);
    check_eq("clean_seq_count", seq_idx, 640);
    check_eq("clean_done", 32'(o_done), 1);
    check_eq("clean_pass", 32'(o_pass), 1);
    check_eq("clean_fa", 32'(o_fail_addr), 0);
    check_eq("clean_fd", 32'(o_fail_data), 0);
    check_eq("clean_busy", 32'(o_busy), 0);
    check_eq("clean_e", 32'(o_mem_e), 0);
    check_eq("clean_rw", 32'(o_mem_rw), 1);

    // Stuck-at-1, address 42 bit 0: abort on M1 r0 @42, access 149.
    fault_mode = 1;
    run(0, 1'b0, end_c, busy_c);
    check_eq("sa1_end", end_c, 149);
    check_eq("sa1_busy_cycles", busy_c, 149);
    check_eq("sa1_done", 32'(o_done), 1);
    check_eq("sa1_pass", 32'(o_pass), 0);
    check_eq("sa1_fa", 32'(o_fail_addr), 42);
    check_eq("sa1_fd", 32'(o_fail_data), 1);
    for (int i = 0; i < 5; i++) begin
      check_eq("sa1_e_after", 32'(o_mem_e), 0);
      check_eq("sa1_busy_after", 32'(o_busy), 0);
      @(posedge clk);
      #1;
    end

    // Stuck-at-0, address 1 bit 3: abort on M2 r1 @1, access 195.
    fault_mode = 2;
    run(0, 1'b0, end_c, busy_c);
    check_eq("sa0_end", end_c, 195);
    check_eq("sa0_done", 32'(o_done), 1);
    check_eq("sa0_pass", 32'(o_pass), 0);
    check_eq("sa0_fa", 32'(o_fail_addr), 1);
    check_eq("sa0_fd", 32'(o_fail_data), 7);
    check_eq("sa0_e", 32'(o_mem_e), 0);

    // Start pulsed mid-run is ignored.
    fault_mode = 0;
    run(100, 1'b0, end_c, busy_c);
    check_eq("restart_end", end_c, 640);
    check_eq("restart_busy_cycles", busy_c, 640);
    check_eq("restart_pass", 32'(o_pass), 1);

    // Reset mid-run, then a full fresh run.
    run(300, 1'b1, end_c, busy_c);
    check_eq("rst_run_no_done", end_c, -1);
    repeat (3) @(posedge clk);
    #1;
    check_reset("after_rst_idle");
    run(0, 1'b0, end_c, busy_c);
    check_eq("rerun_end", end_c, 640);
    check_eq("rerun_busy_cycles", busy_c, 640);
    check_eq("rerun_pass", 32'(o_pass), 1);
    check_eq("rerun_fa", 32'(o_fail_addr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
